// File: rtl/fir_sample_writer.sv
// fir_sample_writer: writes incoming audio samples into a circular tap RAM,
// kicks the FIR engine with the oldest-sample address, and captures its
// result. A watchdog bounds the wait for the engine and sets a sticky error
// when it expires. All outputs are registered and line up with the state
// they belong to.
module fir_sample_writer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  num_taps_m1,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [6:0]  ram_wr_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic        filt_reset,
  output logic [6:0]  filt_start_addr,
  output logic [6:0]  filt_last_addr,
  input  logic        filt_done,
  input  logic [15:0] filt_result,
  output logic [15:0] result_out,
  output logic        result_valid,
  output logic        timeout_err
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    START,
    SETTLE,
    RUN,
    OUTPUT
  } state_t;

  state_t        r_state, w_state;
  logic          r_taps_ok, w_taps_ok;
  logic [6:0]    r_last, w_last;
  logic [6:0]    r_clr_addr, w_clr_addr;
  logic [6:0]    r_wr_ptr, w_wr_ptr;
  logic [CW-1:0] r_cnt, w_cnt;

  logic          r_sample_ready, w_sample_ready;
  logic [6:0]    r_ram_wr_addr, w_ram_wr_addr;
  logic [15:0]   r_ram_wr_data, w_ram_wr_data;
  logic          r_ram_wr_en, w_ram_wr_en;
  logic          r_filt_reset, w_filt_reset;
  logic [6:0]    r_filt_start_addr, w_filt_start_addr;
  logic [6:0]    r_filt_last_addr, w_filt_last_addr;
  logic [15:0]   r_result_out, w_result_out;
  logic          r_result_valid, w_result_valid;
  logic          r_timeout_err, w_timeout_err;

  logic [6:0]    w_ptr_adv;

  // Ring pointer wraps to 0 after the latched last tap index.
  assign w_ptr_adv = (r_wr_ptr == r_last) ? '0 : r_wr_ptr + 7'd1;

  // Next-state and next-output decode. Outputs are computed for the state
  // being entered so that, once registered, they coincide with that state.
  always_comb begin
    w_state           = r_state;
    w_taps_ok         = r_taps_ok;
    w_last            = r_last;
    w_clr_addr        = r_clr_addr;
    w_wr_ptr          = r_wr_ptr;
    w_cnt             = r_cnt;
    w_sample_ready    = 1'b0;
    w_ram_wr_addr     = r_ram_wr_addr;
    w_ram_wr_data     = r_ram_wr_data;
    w_ram_wr_en       = 1'b0;
    w_filt_reset      = 1'b0;
    w_filt_start_addr = r_filt_start_addr;
    w_filt_last_addr  = r_filt_last_addr;
    w_result_out      = r_result_out;
    w_result_valid    = 1'b0;
    w_timeout_err     = r_timeout_err;

    case (r_state)
      CLEAR: begin
        if (!r_taps_ok) begin
          // First cycle out of reset: latch ring length and issue the
          // write of address 0 at the same time.
          w_taps_ok        = 1'b1;
          w_last           = num_taps_m1;
          w_filt_last_addr = num_taps_m1;
          w_clr_addr       = '0;
          w_ram_wr_en      = 1'b1;
          w_ram_wr_addr    = '0;
          w_ram_wr_data    = '0;
        end else if (r_clr_addr == r_last) begin
          w_state        = IDLE;
          w_sample_ready = 1'b1;
          w_wr_ptr       = '0;
        end else begin
          w_clr_addr    = r_clr_addr + 7'd1;
          w_ram_wr_en   = 1'b1;
          w_ram_wr_addr = r_clr_addr + 7'd1;
          w_ram_wr_data = '0;
        end
      end

      IDLE: begin
        if (sample_valid && r_sample_ready) begin
          w_state       = WRITE;
          w_ram_wr_en   = 1'b1;
          w_ram_wr_addr = r_wr_ptr;
          w_ram_wr_data = sample_in;
        end else begin
          w_sample_ready = 1'b1;
        end
      end

      WRITE: begin
        w_state           = START;
        w_wr_ptr          = w_ptr_adv;
        w_filt_reset      = 1'b1;
        w_filt_start_addr = w_ptr_adv;
        w_cnt             = '0;
      end

      START: begin
        w_cnt = '0;
        if (SETTLE_CYCLES == 0) begin
          w_state = RUN;
        end else begin
          w_state = SETTLE;
        end
      end

      SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state = RUN;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      RUN: begin
        if (filt_done) begin
          w_state        = OUTPUT;
          w_result_out   = filt_result;
          w_result_valid = 1'b1;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state        = IDLE;
          w_timeout_err  = 1'b1;
          w_sample_ready = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      OUTPUT: begin
        w_state        = IDLE;
        w_sample_ready = 1'b1;
      end

      default: begin
        w_state = CLEAR;
      end
    endcase
  end

  // State and output registers; reset holds the filter cleared and restarts CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= CLEAR;
      r_taps_ok         <= 1'b0;
      r_last            <= '0;
      r_clr_addr        <= '0;
      r_wr_ptr          <= '0;
      r_cnt             <= '0;
      r_sample_ready    <= 1'b0;
      r_ram_wr_addr     <= '0;
      r_ram_wr_data     <= '0;
      r_ram_wr_en       <= 1'b0;
      r_filt_reset      <= 1'b1;
      r_filt_start_addr <= '0;
      r_filt_last_addr  <= '0;
      r_result_out      <= '0;
      r_result_valid    <= 1'b0;
      r_timeout_err     <= 1'b0;
    end else begin
      r_state           <= w_state;
      r_taps_ok         <= w_taps_ok;
      r_last            <= w_last;
      r_clr_addr        <= w_clr_addr;
      r_wr_ptr          <= w_wr_ptr;
      r_cnt             <= w_cnt;
      r_sample_ready    <= w_sample_ready;
      r_ram_wr_addr     <= w_ram_wr_addr;
      r_ram_wr_data     <= w_ram_wr_data;
      r_ram_wr_en       <= w_ram_wr_en;
      r_filt_reset      <= w_filt_reset;
      r_filt_start_addr <= w_filt_start_addr;
      r_filt_last_addr  <= w_filt_last_addr;
      r_result_out      <= w_result_out;
      r_result_valid    <= w_result_valid;
      r_timeout_err     <= w_timeout_err;
    end
  end

  assign sample_ready    = r_sample_ready;
  assign ram_wr_addr     = r_ram_wr_addr;
  assign ram_wr_data     = r_ram_wr_data;
  assign ram_wr_en       = r_ram_wr_en;
  assign filt_reset      = r_filt_reset;
  assign filt_start_addr = r_filt_start_addr;
  assign filt_last_addr  = r_filt_last_addr;
  assign result_out      = r_result_out;
  assign result_valid    = r_result_valid;
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_fir_sample_writer.sv
// Directed bench for fir_sample_writer: ring clear, sample write/launch
// sequencing, settle masking, timeout, and reset abort.
module tb_fir_sample_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  num_taps_m1;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [6:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        filt_reset;
  logic [6:0]  filt_start_addr;
  logic [6:0]  filt_last_addr;
  logic        filt_done;
  logic [15:0] filt_result;
  logic [15:0] result_out;
  logic        result_valid;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_sample_writer #(
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .num_taps_m1    (num_taps_m1),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .ram_wr_addr    (ram_wr_addr),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_en      (ram_wr_en),
    .filt_reset     (filt_reset),
    .filt_start_addr(filt_start_addr),
    .filt_last_addr (filt_last_addr),
    .filt_done      (filt_done),
    .filt_result    (filt_result),
    .result_out     (result_out),
    .result_valid   (result_valid),
    .timeout_err    (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reset, release, and walk the clear sequence of a ring of last+1 entries.
  task automatic do_clear(input logic [6:0] last);
    reset        = 1'b1;
    sample_valid = 1'b0;
    filt_done    = 1'b0;
    num_taps_m1  = last;
    tick();
    chk("abort_filt_reset", filt_reset, 1);
    chk("abort_rvalid", result_valid, 0);
    chk("abort_wr_en", ram_wr_en, 0);
    tick();
    chk("rst_filt_reset", filt_reset, 1);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_start_addr", filt_start_addr, 0);
    chk("rst_last_addr", filt_last_addr, 0);
    reset = 1'b0;
    tick();
    chk("clr_last_addr", filt_last_addr, last);
    for (int unsigned i = 0; i <= last; i++) begin
      chk("clr_wr_en", ram_wr_en, 1);
      chk("clr_addr", ram_wr_addr, i);
      chk("clr_data", ram_wr_data, 0);
      chk("clr_ready", sample_ready, 0);
      tick();
    end
    chk("clr_done_ready", sample_ready, 1);
    chk("clr_done_wr_en", ram_wr_en, 0);
  endtask

  // One sample transaction. Cycle k counts from the accept edge (k=1 is WRITE).
  // done_from=0 means filt_done never rises (timeout expected at exp_end).
  task automatic txn(input logic [15:0] data, input logic [6:0] wa, input logic [6:0] sa,
                     input int done_from, input int exp_end, input logic [15:0] res,
                     input bit hold_valid, input logic [15:0] prev_res);
    sample_in    = data;
    sample_valid = 1'b1;
    filt_result  = res;
    tick();
    for (int k = 1; k <= exp_end; k++) begin
      if (!hold_valid) sample_valid = 1'b0;
      filt_done = (done_from != 0) && (k >= done_from);
      if (k == 1) begin
        chk("wr_en", ram_wr_en, 1);
        chk("wr_addr", ram_wr_addr, wa);
        chk("wr_data", ram_wr_data, data);
        chk("wr_ready", sample_ready, 0);
      end else begin
        chk("busy_wr_en", ram_wr_en, 0);
      end
      if (k == 2) begin
        chk("start_filt_reset", filt_reset, 1);
        chk("start_addr", filt_start_addr, sa);
      end
      if (k == 3) chk("settle_filt_reset", filt_reset, 0);
      if (k < exp_end) begin
        chk("early_rvalid", result_valid, 0);
        chk("busy_ready", sample_ready, 0);
      end
      if (k == exp_end) begin
        chk("start_addr_stable", filt_start_addr, sa);
        if (done_from == 0) begin
          chk("to_flag", timeout_err, 1);
          chk("to_ready", sample_ready, 1);
          chk("to_rvalid", result_valid, 0);
          chk("to_result_kept", result_out, prev_res);
        end else begin
          chk("out_rvalid", result_valid, 1);
          chk("out_result", result_out, res);
          chk("out_ready", sample_ready, 0);
        end
      end
      tick();
    end
    sample_valid = 1'b0;
    filt_done    = 1'b0;
    chk("post_rvalid", result_valid, 0);
    chk("post_ready", sample_ready, 1);
  endtask

  initial begin
    reset        = 1'b1;
    num_taps_m1  = 7'd3;
    sample_in    = '0;
    sample_valid = 1'b0;
    filt_done    = 1'b0;
    filt_result  = '0;

    do_clear(7'd3);
    // Ring length was latched; later changes on the pin must not matter.
    num_taps_m1 = 7'd5;

    txn(16'h1234, 7'd0, 7'd1, 6, 7,  16'h0ABC, 1'b0, 16'h0000);
    txn(16'hBEEF, 7'd1, 7'd2, 2, 6,  16'h5555, 1'b0, 16'h0ABC);
    txn(16'h8001, 7'd2, 7'd3, 8, 9,  16'h7F00, 1'b1, 16'h5555);
    txn(16'h0042, 7'd3, 7'd0, 0, 13, 16'hDEAD, 1'b0, 16'h7F00);
    txn(16'hFFFF, 7'd0, 7'd1, 5, 6,  16'h1357, 1'b0, 16'h7F00);
    chk("timeout_sticky", timeout_err, 1);
    chk("last_addr_hold", filt_last_addr, 3);

    // Reset while RUN: accept, advance to k=6 (RUN), then reset.
    num_taps_m1  = 7'd3;
    sample_in    = 16'h2222;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (5) tick();
    do_clear(7'd3);
    txn(16'h3333, 7'd0, 7'd1, 5, 6, 16'h2468, 1'b0, 16'h0000);

    // Reset while mid-CLEAR, then a one-entry ring.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    do_clear(7'd0);
    txn(16'h0101, 7'd0, 7'd0, 5, 6, 16'h0F0F, 1'b0, 16'h0000);
    txn(16'h0202, 7'd0, 7'd0, 6, 7, 16'h0E0E, 1'b0, 16'h0F0F);
    chk("one_entry_last", filt_last_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_sample_writer.md
FIR_SAMPLE_WRITER -- requirements
Module: fir_sample_writer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles after the filter start pulse during which filt_done is ignored.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, maximum RUN cycles to wait for filt_done.
REQ-003 Port: clk, input, 1, sole clock; all logic rising-edge.
REQ-004 Port: reset, input, 1, synchronous, active-high.
REQ-005 Port: num_taps_m1, input, 7, ring length minus one; latched on the first cycle after reset deasserts.
REQ-006 Port: sample_in, input, 16, signed audio sample.
REQ-007 Port: sample_valid, input, 1, sample_in valid.
REQ-008 Port: sample_ready, output, 1, block accepts sample this cycle.
REQ-009 Port: ram_wr_addr, output, 7, audio ring write address.
REQ-010 Port: ram_wr_data, output, 16, audio ring write data.
REQ-011 Port: ram_wr_en, output, 1, audio ring write strobe.
REQ-012 Port: filt_reset, output, 1, filter start/clear strobe.
REQ-013 Port: filt_start_addr, output, 7, oldest-sample address for the filter.
REQ-014 Port: filt_last_addr, output, 7, ring wrap/kernel end address; equals the latched num_taps_m1.
REQ-015 Port: filt_done, input, 1, filter finished.
REQ-016 Port: filt_result, input, 16, filter output; valid while filt_done is high.
REQ-017 Port: result_out, output, 16, captured filter result.
REQ-018 Port: result_valid, output, 1, one-cycle result strobe.
REQ-019 Port: timeout_err, output, 1, sticky flag; set when TIMEOUT_CYCLES expires.

Function
REQ-020 States SHALL be CLEAR, IDLE, WRITE, START, SETTLE, RUN and OUTPUT; all outputs SHALL be registered.
REQ-021 CLEAR SHALL write 0 to addresses 0..num_taps_m1, one per cycle with ram_wr_en high, then go to IDLE; wr_ptr SHALL equal 0 on entry to IDLE.
REQ-022 sample_ready SHALL be high only in IDLE; a sample is accepted on the cycle where sample_valid and sample_ready are both high.
REQ-023 On accept at cycle T, the block SHALL be in WRITE at T+1: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=sample_in captured at T.
REQ-024 At the end of WRITE, wr_ptr SHALL advance to 0 if wr_ptr==num_taps_m1, else to wr_ptr+1.
REQ-025 START (T+2) SHALL hold filt_reset=1 for exactly one cycle, with filt_start_addr equal to the advanced wr_ptr (the oldest sample).
REQ-026 SETTLE SHALL last SETTLE_CYCLES cycles, ignoring filt_done, then go to RUN.
REQ-027 In RUN, filt_done=1 SHALL capture filt_result into result_out and move to OUTPUT.
REQ-028 OUTPUT SHALL assert result_valid for exactly one cycle, then return to IDLE.
REQ-029 If RUN reaches TIMEOUT_CYCLES without filt_done, the block SHALL set timeout_err, leave result_out unchanged, skip the result_valid pulse, and return to IDLE.
REQ-030 sample_valid outside IDLE SHALL be ignored; the source holds data until sample_ready.
REQ-031 num_taps_m1=0 SHALL give a one-entry ring: wr_ptr stays 0, and filt_start_addr=0.
REQ-032 filt_start_addr and filt_last_addr SHALL hold stable from START until the next START.

Reset
REQ-033 While reset is high: filt_reset=1, ram_wr_en=0, sample_ready=0, result_valid=0, result_out=0, timeout_err=0, wr_ptr=0, filt_start_addr=0, filt_last_addr=0, state=CLEAR.
REQ-034 Reset asserted in any state, including mid-CLEAR or mid-RUN, SHALL abort the operation the next cycle with no result_valid pulse, and CLEAR SHALL restart from address 0.

Verification
REQ-035 num_taps_m1=3, release reset -> ram_wr_en on addresses 0,1,2,3 with data 0 on four consecutive cycles, then sample_ready=1.
REQ-036 Accept 0x1234 at T -> T+1 write addr 0 data 0x1234; T+2 filt_reset=1 with filt_start_addr=1; filt_done at T+6 with filt_result=0x0ABC -> result_valid at T+7 with result_out=0x0ABC.
REQ-037 num_taps_m1=3, five samples -> write addresses 0,1,2,3,0; filt_start_addr 1,2,3,0,1.
REQ-038 filt_done held high throughout -> no capture before SETTLE completes; result_valid one cycle after RUN entry.
REQ-039 filt_done never asserted, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 RUN cycles, no result_valid, sample_ready=1 next cycle.
REQ-040 Reset pulsed during RUN -> filt_reset=1 and result_valid=0, CLEAR rewrites from address 0, and the first new write goes to address 0.
